// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and limits for the sequential divider
// State bits map directly onto the {Qi,Qc,Qd} flag outputs.
package divider_pkg;

   localparam int MAX_WIDTH = 16;

   localparam logic [2:0] QI = 3'b100;
   localparam logic [2:0] QC = 3'b010;
   localparam logic [2:0] QD = 3'b001;

   typedef enum logic [2:0] {
      ST_QI = QI,
      ST_QC = QC,
      ST_QD = QD
   } state_e;

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one restoring shift-subtract stage of the divider
// Combinational: shifts the quotient MSB into the remainder and tries the subtract.
module divider_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             quo_msb_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_bit_o
);

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff;

   // Low bits of the difference are exact whenever the subtract is taken.
   assign trial   = {rem_i, quo_msb_i};
   assign diff    = trial[WIDTH-1:0] - divisor_i;
   assign q_bit_o = (trial >= {1'b0, divisor_i});
   assign rem_o   = q_bit_o ? diff : trial[WIDTH-1:0];

endmodule

// File: rtl/divider_nbit.sv
// rtl/divider_nbit.sv - WIDTH-bit sequential unsigned divider with Start/Ack handshake
// Optional DIVIDER_DIV_ZERO_DETECT_EN: zero divisor skips compute and flags DivByZero.
module divider_nbit
   import divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             ack_i,
   input  logic [WIDTH-1:0] xin_i,
   input  logic [WIDTH-1:0] yin_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             done_o,
   output logic             qi_o,
   output logic             qc_o,
   output logic             qd_o,
   output logic             div_by_zero_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
      $error("divider_nbit: WIDTH out of range");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] step_rem;
   logic             step_bit;

   divider_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_i    (rem_q),
      .quo_msb_i(quo_q[WIDTH-1]),
      .divisor_i(div_q),
      .rem_o    (step_rem),
      .q_bit_o  (step_bit)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_QI;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         ST_QI: begin
            if (start_i) begin
               div_d   = yin_i;
               rem_d   = '0;
               quo_d   = xin_i;
               cnt_d   = CW'(WIDTH - 1);
               dbz_d   = 1'b0;
               state_d = ST_QC;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
               if (yin_i == '0) begin
                  quo_d   = '1;
                  rem_d   = xin_i;
                  cnt_d   = '0;
                  dbz_d   = 1'b1;
                  state_d = ST_QD;
               end
`endif
            end
         end
         ST_QC: begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], step_bit};
            if (cnt_q == '0) begin
               state_d = ST_QD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_QD: begin
            if (ack_i) begin
               state_d = ST_QI;
            end
         end
         default: begin
            state_d = ST_QI;
         end
      endcase
   end

   assign quotient_o    = quo_q;
   assign remainder_o   = rem_q;
   assign {qi_o, qc_o, qd_o} = state_q;
   assign done_o        = (state_q == ST_QD);
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divider_nbit.sv
// tb/tb_divider_nbit.sv - scoreboard bench for divider_nbit at WIDTH 8 and 4
// Expected results are hand-computed and queued at Start; a monitor checks them at Done.
module tb_divider_nbit;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
      int         done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic       start8 = 1'b0, ack8 = 1'b0;
   logic [7:0] xin8 = '0, yin8 = '0, quo8, rem8;
   logic       done8, qi8, qc8, qd8, dbz8;

   logic       start4 = 1'b0, ack4 = 1'b0;
   logic [3:0] xin4 = '0, yin4 = '0, quo4, rem4;
   logic       done4, qi4, qc4, qd4, dbz4;

   exp_t q8[$];
   exp_t q4[$];
   logic prev8 = 1'b0, prev4 = 1'b0;

`ifdef DIVIDER_DIV_ZERO_DETECT_EN
   localparam int  ZLAT = 0;
   localparam logic ZDBZ = 1'b1;
`else
   localparam int  ZLAT = 8;
   localparam logic ZDBZ = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   divider_nbit #(.WIDTH(8)) dut8 (
      .clk_i(clk), .reset_i(reset), .start_i(start8), .ack_i(ack8),
      .xin_i(xin8), .yin_i(yin8), .quotient_o(quo8), .remainder_o(rem8),
      .done_o(done8), .qi_o(qi8), .qc_o(qc8), .qd_o(qd8), .div_by_zero_o(dbz8)
   );

   divider_nbit #(.WIDTH(4)) dut4 (
      .clk_i(clk), .reset_i(reset), .start_i(start4), .ack_i(ack4),
      .xin_i(xin4), .yin_i(yin4), .quotient_o(quo4), .remainder_o(rem4),
      .done_o(done4), .qi_o(qi4), .qc_o(qc4), .qd_o(qd4), .div_by_zero_o(dbz4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (done8 && !prev8) begin
         if (q8.size() == 0) begin
            chk("w8_unexpected_done", 1, 0);
         end else begin
            e = q8.pop_front();
            chk("w8_quotient", quo8, e.q);
            chk("w8_remainder", rem8, e.r);
            chk("w8_divbyzero", dbz8, e.dbz);
            chk("w8_latency_edge", cyc, e.done_cyc);
            chk("w8_flags_qd", {qi8, qc8, qd8}, 3'b001);
         end
      end
      if (done4 && !prev4) begin
         if (q4.size() == 0) begin
            chk("w4_unexpected_done", 1, 0);
         end else begin
            e = q4.pop_front();
            chk("w4_quotient", quo4, e.q);
            chk("w4_remainder", rem4, e.r);
            chk("w4_latency_edge", cyc, e.done_cyc);
         end
      end
      prev8 <= done8;
      prev4 <= done4;
   end

   // Drives one Start (optionally also Ack) pulse; operands are scrambled afterwards.
   task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] eq,
                      input logic [7:0] er, input logic edbz, input int lat, input logic tied);
      exp_t e;
      @(negedge clk);
      xin8 = x; yin8 = y; start8 = 1'b1; ack8 = tied;
      e.q = eq; e.r = er; e.dbz = edbz; e.done_cyc = cyc + 1 + lat;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0; ack8 = 1'b0; xin8 = ~x; yin8 = ~y;
   endtask

   task automatic wait_done8(input string name);
      int n = 0;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done8) chk(name, 0, 1);
   endtask

   task automatic ack_pulse8(input logic tied, input logic [7:0] hq, input logic [7:0] hr);
      @(negedge clk);
      ack8 = 1'b1; start8 = tied;
      @(negedge clk);
      ack8 = 1'b0; start8 = 1'b0;
      chk("w8_ack_to_qi", {qi8, qc8, qd8, done8}, 4'b1000);
      chk("w8_held_quotient", quo8, hq);
      chk("w8_held_remainder", rem8, hr);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_flags", {qi8, qc8, qd8, done8, dbz8}, 5'b10000);
      chk("rst_results", {quo8, rem8}, 16'h0000);
      reset = 1'b0;

      go8(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8, 1'b0);
      chk("w8_in_compute", {qi8, qc8, qd8}, 3'b010);
      wait_done8("w8_timeout_a");
      ack_pulse8(1'b0, 8'd28, 8'd4);

      go8(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8, 1'b0);
      wait_done8("w8_timeout_b");
      ack_pulse8(1'b0, 8'd0, 8'd5);

      go8(8'hA5, 8'd0, 8'hFF, 8'hA5, ZDBZ, ZLAT, 1'b0);
      wait_done8("w8_timeout_zero");
      ack_pulse8(1'b0, 8'hFF, 8'hA5);

      go8(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8, 1'b0);
      wait_done8("w8_timeout_c");
      ack_pulse8(1'b0, 8'd1, 8'd0);
      go8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8, 1'b0);
      wait_done8("w8_timeout_d");
      ack_pulse8(1'b0, 8'd255, 8'd0);

      // WIDTH=4: 15/1 completes after 5 edges counting the Start edge.
      begin
         exp_t e;
         @(negedge clk);
         xin4 = 4'd15; yin4 = 4'd1; start4 = 1'b1;
         e.q = 8'd15; e.r = 8'd0; e.dbz = 1'b0; e.done_cyc = cyc + 1 + 4;
         q4.push_back(e);
         @(negedge clk);
         start4 = 1'b0; xin4 = 4'd3; yin4 = 4'd3;
         repeat (6) @(negedge clk);
         chk("w4_done", {qd4, done4, dbz4}, 3'b110);
         ack4 = 1'b1;
         @(negedge clk);
         ack4 = 1'b0;
         chk("w4_ack_to_qi", {qi4, qc4, qd4}, 3'b100);
      end

      // Start and Ack tied to one pulse source.
      go8(8'd77, 8'd3, 8'd25, 8'd2, 1'b0, 8, 1'b1);
      @(negedge clk);
      start8 = 1'b1; ack8 = 1'b1; xin8 = 8'd9; yin8 = 8'd1;
      @(negedge clk);
      start8 = 1'b0; ack8 = 1'b0;
      chk("tied_extra_pulse_ignored", {qi8, qc8, qd8}, 3'b010);
      wait_done8("tied_timeout_1");
      ack_pulse8(1'b1, 8'd25, 8'd2);
      go8(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 8, 1'b1);
      wait_done8("tied_timeout_3");
      ack_pulse8(1'b1, 8'd10, 8'd0);

      // Reset in the 4th compute cycle, with Start asserted alongside it.
      @(negedge clk);
      xin8 = 8'd200; yin8 = 8'd7; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_reset_in_qc", qc8, 1'b1);
      reset = 1'b1; start8 = 1'b1;
      @(negedge clk);
      chk("mid_reset_flags", {qi8, qc8, qd8, done8}, 4'b1000);
      chk("mid_reset_results", {quo8, rem8}, 16'h0000);
      reset = 1'b0; start8 = 1'b0;
      @(negedge clk);
      chk("start_with_reset_ignored", {qi8, qc8}, 2'b10);

      go8(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 8, 1'b0);
      wait_done8("post_reset_timeout");
      ack_pulse8(1'b0, 8'd4, 8'd1);

      repeat (2) @(negedge clk);
      chk("w8_queue_drained", q8.size(), 0);
      chk("w4_queue_drained", q4.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
